regfile_2r1w: RTL and testbench

Parametrised two-read/one-write register file with write-first bypass, optional hardwired-zero register 0, and a per-register busy scoreboard. It supersedes the single-register load unit as the datapath's general-purpose register bank. It sits between decode (reads and reservations) and writeback (writes), and gives the control unit hazard status with the read data.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 28 ++
 rtl/regfile_2r1w.sv | 51 +++++
 tb/tb_regfile_2r1w.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, depth helper and busy-vector type for the register file
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);
  typedef logic [DEPTH_DEF-1:0] busy_vec_t;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: decode/writeback bus of the register file
// master = decode/writeback side (drives write, reads, reserve); slave = regfile_2r1w
interface regfile_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_pkg::ADDR_W_DEF
);
  import regfile_pkg::*;
  localparam int DEPTH = depth_of(ADDR_W);
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              rp_en;
  logic [ADDR_W-1:0] rp_addr;
  logic [DATA_W-1:0] rp_data;
  logic              rp_busy;
  logic              rq_en;
  logic [ADDR_W-1:0] rq_addr;
  logic [DATA_W-1:0] rq_data;
  logic              rq_busy;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [DEPTH-1:0]  busy_vec;
  modport master (
    output w_en, w_addr, w_data, rp_en, rp_addr, rq_en, rq_addr, rsv_en, rsv_addr,
    input  rp_data, rp_busy, rq_data, rq_busy, busy_vec
  );
  modport slave (
    input  w_en, w_addr, w_data, rp_en, rp_addr, rq_en, rq_addr, rsv_en, rsv_addr,
    output rp_data, rp_busy, rq_data, rq_busy, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy flops; reserve beats write-clear, register 0 masked when ZERO_REG
// ports: clk, rst (async active-low), w_en/w_addr clear, rsv_en/rsv_addr set,
//        busy (flop state), busy_next (state after this edge, used by the read ports)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  busy,
  output logic [DEPTH-1:0]  busy_next
);
  always_comb begin
    busy_next = busy;
    if (w_en) busy_next[w_addr] = 1'b0;
    if (rsv_en && !(ZERO_REG != 0 && rsv_addr == '0)) busy_next[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy <= '0;
    else busy <= busy_next;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with write-first bypass, optional zero register and busy scoreboard
// ports: clk, rst (async active-low), bus (regfile_if.slave: write, two read ports, reserve, busy_vec)
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = depth_of(ADDR_W)
) (
  input logic       clk,
  input logic       rst,
  regfile_if.slave  bus
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_next;
  logic              w_ok;
  logic [DATA_W-1:0] rp_val, rq_val;
  // mem[0] is never written when ZERO_REG, so it reads back its reset value of 0
  assign w_ok   = bus.w_en && !(ZERO_REG != 0 && bus.w_addr == '0);
  assign rp_val = (w_ok && bus.w_addr == bus.rp_addr) ? bus.w_data : mem[bus.rp_addr];
  assign rq_val = (w_ok && bus.w_addr == bus.rq_addr) ? bus.w_data : mem[bus.rq_addr];
  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .w_en      (bus.w_en),
    .w_addr    (bus.w_addr),
    .rsv_en    (bus.rsv_en),
    .rsv_addr  (bus.rsv_addr),
    .busy      (bus.busy_vec),
    .busy_next (busy_next)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem         <= '{default: '0};
      bus.rp_data <= '0;
      bus.rp_busy <= 1'b0;
      bus.rq_data <= '0;
      bus.rq_busy <= 1'b0;
    end else begin
      if (w_ok) mem[bus.w_addr] <= bus.w_data;
      if (bus.rp_en) begin
        bus.rp_data <= rp_val;
        bus.rp_busy <= busy_next[bus.rp_addr];
      end
      if (bus.rq_en) begin
        bus.rq_data <= rq_val;
        bus.rq_busy <= busy_next[bus.rq_addr];
      end
    end
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: three configurations driven in lockstep and checked against a behavioural model
module tb_regfile_2r1w;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic        w_en, rp_en, rq_en, rsv_en;
  logic [4:0]  w_addr, rp_addr, rq_addr, rsv_addr;
  logic [31:0] w_data;
  int errs = 0;
  int checks = 0;
  regfile_if #(.DATA_W(16), .ADDR_W(4)) a_if ();
  regfile_if #(.DATA_W(16), .ADDR_W(4)) z_if ();
  regfile_if #(.DATA_W(32), .ADDR_W(5)) w_if ();
  assign a_if.w_en = w_en;  assign a_if.w_addr = w_addr[3:0];  assign a_if.w_data = w_data[15:0];
  assign a_if.rp_en = rp_en; assign a_if.rp_addr = rp_addr[3:0];
  assign a_if.rq_en = rq_en; assign a_if.rq_addr = rq_addr[3:0];
  assign a_if.rsv_en = rsv_en; assign a_if.rsv_addr = rsv_addr[3:0];
  assign z_if.w_en = w_en;  assign z_if.w_addr = w_addr[3:0];  assign z_if.w_data = w_data[15:0];
  assign z_if.rp_en = rp_en; assign z_if.rp_addr = rp_addr[3:0];
  assign z_if.rq_en = rq_en; assign z_if.rq_addr = rq_addr[3:0];
  assign z_if.rsv_en = rsv_en; assign z_if.rsv_addr = rsv_addr[3:0];
  assign w_if.w_en = w_en;  assign w_if.w_addr = w_addr;  assign w_if.w_data = w_data;
  assign w_if.rp_en = rp_en; assign w_if.rp_addr = rp_addr;
  assign w_if.rq_en = rq_en; assign w_if.rq_addr = rq_addr;
  assign w_if.rsv_en = rsv_en; assign w_if.rsv_addr = rsv_addr;
  regfile_2r1w #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  regfile_2r1w #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut_z (.clk(clk), .rst(rst), .bus(z_if));
  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_w (.clk(clk), .rst(rst), .bus(w_if));
  logic [31:0] o_rpd [3];
  logic [31:0] o_rqd [3];
  logic [31:0] o_bv  [3];
  logic        o_rpb [3];
  logic        o_rqb [3];
  assign o_rpd[0] = 32'(a_if.rp_data); assign o_rqd[0] = 32'(a_if.rq_data); assign o_bv[0] = 32'(a_if.busy_vec);
  assign o_rpd[1] = 32'(z_if.rp_data); assign o_rqd[1] = 32'(z_if.rq_data); assign o_bv[1] = 32'(z_if.busy_vec);
  assign o_rpd[2] = w_if.rp_data;      assign o_rqd[2] = w_if.rq_data;      assign o_bv[2] = w_if.busy_vec;
  assign o_rpb[0] = a_if.rp_busy; assign o_rqb[0] = a_if.rq_busy;
  assign o_rpb[1] = z_if.rp_busy; assign o_rqb[1] = z_if.rq_busy;
  assign o_rpb[2] = w_if.rp_busy; assign o_rqb[2] = w_if.rq_busy;
  // Reference model: index 0 = 16b/16 regs/zero reg, 1 = 16b/16 regs/plain, 2 = 32b/32 regs/zero reg
  logic [31:0] m_mem [3][32];
  bit          m_busy [3][32];
  logic [31:0] m_rpd [3];
  logic [31:0] m_rqd [3];
  bit          m_rpb [3];
  bit          m_rqb [3];
  function automatic int naddr(int k);
    return k == 2 ? 32 : 16;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i] = '0;
        m_busy[k][i] = 1'b0;
      end
      m_rpd[k] = '0; m_rqd[k] = '0; m_rpb[k] = 1'b0; m_rqb[k] = 1'b0;
    end
  endtask
  // One clock edge: apply the write, then the reserve (so it wins), then read the resulting state
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int n = naddr(k);
      bit zr = (k != 1);
      int wa = int'(w_addr) % n;
      int sa = int'(rsv_addr) % n;
      int pa = int'(rp_addr) % n;
      int qa = int'(rq_addr) % n;
      logic [31:0] dm = (k == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      if (w_en && !(zr && wa == 0)) m_mem[k][wa] = w_data & dm;
      if (w_en) m_busy[k][wa] = 1'b0;
      if (rsv_en && !(zr && sa == 0)) m_busy[k][sa] = 1'b1;
      if (rp_en) begin m_rpd[k] = m_mem[k][pa]; m_rpb[k] = m_busy[k][pa]; end
      if (rq_en) begin m_rqd[k] = m_mem[k][qa]; m_rqb[k] = m_busy[k][qa]; end
    end
  endtask
  function automatic logic [31:0] m_bv(int k);
    logic [31:0] v = '0;
    for (int i = 0; i < naddr(k); i++) v[i] = m_busy[k][i];
    return v;
  endfunction
  task automatic idle();
    w_en = 0; rp_en = 0; rq_en = 0; rsv_en = 0;
    w_addr = 0; rp_addr = 0; rq_addr = 0; rsv_addr = 0; w_data = 0;
  endtask
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask
  task automatic test_reset();
    idle();
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_rpd[k] !== 0 || o_rqd[k] !== 0 || o_bv[k] !== 0) begin
        errs++; $display("FAIL reset_state cfg%0d rp=%h rq=%h bv=%h want 0", k, o_rpd[k], o_rqd[k], o_bv[k]);
      end
    end
    rst = 1'b1;
    w_en = 1; w_addr = 3; w_data = 32'h1234; rsv_en = 1; rsv_addr = 6;
    step();
    idle(); rp_en = 1; rp_addr = 3; rq_en = 1; rq_addr = 3;
    step();
    checks++;
    if (o_rpd[0] !== 32'h1234) begin errs++; $display("FAIL pre_reset_read got %h want 1234", o_rpd[0]); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_rpd[0] !== 0 || o_rqd[0] !== 0 || o_bv[0] !== 0) begin
      errs++; $display("FAIL async_reset rp=%h rq=%h bv=%h want 0", o_rpd[0], o_rqd[0], o_bv[0]);
    end
    @(negedge clk);
    w_en = 1; w_addr = 3; w_data = 32'h5555; rsv_en = 1; rsv_addr = 3;
    step();
    rst = 1'b1;
    idle(); rp_en = 1; rp_addr = 3;
    step();
    checks++;
    if (o_rpd[0] !== 0 || o_bv[0] !== 0) begin
      errs++; $display("FAIL post_reset_read rp=%h bv=%h want 0", o_rpd[0], o_bv[0]);
    end
  endtask
  task automatic test_write_read();
    idle(); w_en = 1; w_addr = 5; w_data = 32'hBEEF;
    step();
    idle(); rp_en = 1; rp_addr = 5; rq_en = 1; rq_addr = 5;
    step();
    checks++;
    if (o_rpd[0] !== 32'hBEEF) begin errs++; $display("FAIL write_read_p got %h want beef", o_rpd[0]); end
    checks++;
    if (o_rqd[0] !== 32'hBEEF) begin errs++; $display("FAIL write_read_q got %h want beef", o_rqd[0]); end
  endtask
  task automatic test_bypass();
    idle(); w_en = 1; w_addr = 7; w_data = 32'hA5A5;
    rp_en = 1; rp_addr = 7; rq_en = 1; rq_addr = 7;
    step();
    checks++;
    if (o_rpd[0] !== 32'hA5A5 || o_rqd[0] !== 32'hA5A5) begin
      errs++; $display("FAIL bypass rp=%h rq=%h want a5a5", o_rpd[0], o_rqd[0]);
    end
  endtask
  task automatic test_scoreboard();
    idle(); rsv_en = 1; rsv_addr = 9;
    step();
    checks++;
    if (o_bv[0][9] !== 1'b1) begin errs++; $display("FAIL reserve_bv got %b want 1", o_bv[0][9]); end
    idle(); rp_en = 1; rp_addr = 9;
    step();
    checks++;
    if (o_rpb[0] !== 1'b1) begin errs++; $display("FAIL reserve_rp_busy got %b want 1", o_rpb[0]); end
    idle();
    step();
    w_en = 1; w_addr = 9; w_data = 32'h0042; rp_en = 1; rp_addr = 9;
    step();
    checks++;
    if (o_rpd[0] !== 32'h0042 || o_rpb[0] !== 1'b0 || o_bv[0][9] !== 1'b0) begin
      errs++; $display("FAIL write_clears rp=%h busy=%b bv9=%b want 0042 0 0", o_rpd[0], o_rpb[0], o_bv[0][9]);
    end
    rsv_en = 1; rsv_addr = 9; w_data = 32'h0077;
    step();
    checks++;
    if (o_rpd[0] !== 32'h0077 || o_rpb[0] !== 1'b1 || o_bv[0][9] !== 1'b1) begin
      errs++; $display("FAIL reserve_wins rp=%h busy=%b bv9=%b want 0077 1 1", o_rpd[0], o_rpb[0], o_bv[0][9]);
    end
  endtask
  task automatic test_zero_reg();
    idle(); w_en = 1; w_addr = 0; w_data = 32'hFFFF; rp_en = 1; rp_addr = 0; rsv_en = 1; rsv_addr = 0;
    step();
    checks++;
    if (o_rpd[0] !== 0 || o_rpb[0] !== 1'b0 || o_bv[0][0] !== 1'b0) begin
      errs++; $display("FAIL zero_reg rp=%h busy=%b bv0=%b want 0 0 0", o_rpd[0], o_rpb[0], o_bv[0][0]);
    end
    checks++;
    if (o_rpd[1] !== 32'hFFFF || o_rpb[1] !== 1'b1 || o_bv[1][0] !== 1'b1) begin
      errs++; $display("FAIL plain_reg0 rp=%h busy=%b bv0=%b want ffff 1 1", o_rpd[1], o_rpb[1], o_bv[1][0]);
    end
    idle(); rq_en = 1; rq_addr = 0;
    step();
    checks++;
    if (o_rqd[0] !== 0 || o_rqd[1] !== 32'hFFFF) begin
      errs++; $display("FAIL reg0_reread zr=%h plain=%h want 0 ffff", o_rqd[0], o_rqd[1]);
    end
  endtask
  task automatic test_hold();
    idle(); w_en = 1; w_addr = 2; w_data = 32'h1111;
    step();
    idle(); rp_en = 1; rp_addr = 2;
    step();
    idle(); w_en = 1; w_addr = 2; w_data = 32'h2222; rp_addr = 2;
    step();
    checks++;
    if (o_rpd[0] !== 32'h1111) begin errs++; $display("FAIL hold got %h want 1111", o_rpd[0]); end
    idle(); rp_en = 1; rp_addr = 2;
    step();
    checks++;
    if (o_rpd[0] !== 32'h2222) begin errs++; $display("FAIL after_hold got %h want 2222", o_rpd[0]); end
  endtask
  task automatic test_wide();
    idle(); w_en = 1; w_addr = 31; w_data = 32'hDEAD_BEEF; rsv_en = 1; rsv_addr = 31;
    step();
    idle(); rp_en = 1; rp_addr = 31; rq_en = 1; rq_addr = 31;
    step();
    checks++;
    if (o_rpd[2] !== 32'hDEAD_BEEF || o_rqd[2] !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL wide_read rp=%h rq=%h want deadbeef", o_rpd[2], o_rqd[2]);
    end
    checks++;
    if (o_bv[2][31] !== 1'b1 || o_rpb[2] !== 1'b1) begin
      errs++; $display("FAIL wide_busy bv31=%b busy=%b want 1 1", o_bv[2][31], o_rpb[2]);
    end
    checks++;
    if (o_rpd[0] !== 32'hBEEF) begin errs++; $display("FAIL narrow_alias got %h want beef", o_rpd[0]); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit near = ($urandom_range(0, 1) == 1);
      w_en = 1'($urandom); rp_en = 1'($urandom); rq_en = 1'($urandom); rsv_en = ($urandom_range(0, 3) == 0);
      w_addr   = near ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rp_addr  = near ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rq_addr  = near ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rsv_addr = near ? 5'($urandom_range(0, 3)) : 5'($urandom);
      w_data = $urandom;
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_rpd[k] !== m_rpd[k] || o_rpb[k] !== m_rpb[k]) begin
          errs++; $display("FAIL rand_p cfg%0d cyc%0d got %h/%b want %h/%b", k, n, o_rpd[k], o_rpb[k], m_rpd[k], m_rpb[k]);
        end
        checks++;
        if (o_rqd[k] !== m_rqd[k] || o_rqb[k] !== m_rqb[k]) begin
          errs++; $display("FAIL rand_q cfg%0d cyc%0d got %h/%b want %h/%b", k, n, o_rqd[k], o_rqb[k], m_rqd[k], m_rqb[k]);
        end
        checks++;
        if (o_bv[k] !== m_bv(k)) begin
          errs++; $display("FAIL rand_bv cfg%0d cyc%0d got %h want %h", k, n, o_bv[k], m_bv(k));
        end
      end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_hold();
    test_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
